axi_reg_slave: RTL

- Responder end of the team's simplified AXI-lite style bus: the slave side that an `axi_cpu` bridge talks to.
- Accepts single-beat writes (wvalid/awaddr/wdata/wstrb) and reads (arvalid/araddr) and backs them with a bank of 32-bit registers.
- Completes each transfer with a one-cycle bvalid or rvalid pulse. The bus has no bready/rready; the initiator always accepts responses.
- Exposes register contents and per-register access strobes to the attached peripheral logic.

---
 rtl/axi_reg_slave.sv | 139 +++++++++++++
 1 files changed

// File: rtl/axi_reg_slave.sv
// Register-bank responder for the simplified AXI-lite bus: single-beat writes
// and reads with one-cycle accept/response pulses and per-register strobes.
module axi_reg_slave #(
  parameter logic [31:0]      BASE_ADDR = 32'h0000_0000,
  parameter int               ADDR_W    = 3,
  parameter int               NREGS     = 8,
  parameter logic [NREGS-1:0] RO_MASK   = '0,
  parameter logic [31:0]      RESET_VAL = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [31:0]           awaddr,
  input  logic [31:0]           wdata,
  input  logic [3:0]            wstrb,
  output logic                  bvalid,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [31:0]           araddr,
  output logic                  rvalid,
  output logic [31:0]           rdata,
  output logic [NREGS*32-1:0]   regs_out,
  input  logic [NREGS*32-1:0]   regs_in,
  output logic [NREGS-1:0]      wr_pulse,
  output logic [NREGS-1:0]      rd_pulse
);

  typedef enum logic [2:0] {IDLE, WACK, WRESP, RACK, RRESP} state_t;

  state_t           state_q, state_d;
  logic             wready_q, wready_d;
  logic             bvalid_q, bvalid_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [NREGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [NREGS-1:0] rd_pulse_q, rd_pulse_d;
  logic [31:0]      regs_q [NREGS];
  logic [31:0]      regs_d [NREGS];

  // The byte offset within a word (addr[1:0]) plays no part in decoding.
  function automatic logic addr_hit(input logic [31:0] addr);
    return (addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]) &&
           (int'(addr[ADDR_W+1:2]) < NREGS);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_idx(input logic [31:0] addr);
    return addr[ADDR_W+1:2];
  endfunction

  always_comb begin
    state_d    = state_q;
    wready_d   = 1'b0;
    bvalid_d   = 1'b0;
    arready_d  = 1'b0;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    wr_pulse_d = '0;
    rd_pulse_d = '0;
    regs_d     = regs_q;

    unique case (state_q)
      IDLE: begin
        if (wvalid) begin
          state_d  = WACK;
          wready_d = 1'b1;
          for (int i = 0; i < NREGS; i++) begin
            if (addr_hit(awaddr) && addr_idx(awaddr) == ADDR_W'(i) && !RO_MASK[i]) begin
              wr_pulse_d[i] = 1'b1;
              for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) regs_d[i][8*k +: 8] = wdata[8*k +: 8];
              end
            end
          end
        end else if (arvalid) begin
          state_d   = RACK;
          arready_d = 1'b1;
          rdata_d   = 32'h0;
          for (int i = 0; i < NREGS; i++) begin
            if (addr_hit(araddr) && addr_idx(araddr) == ADDR_W'(i)) begin
              rd_pulse_d[i] = 1'b1;
              rdata_d       = RO_MASK[i] ? regs_in[32*i +: 32] : regs_q[i];
            end
          end
        end
      end
      WACK: begin
        state_d  = WRESP;
        bvalid_d = 1'b1;
      end
      WRESP: state_d = IDLE;
      RACK: begin
        state_d  = RRESP;
        rvalid_d = 1'b1;
      end
      RRESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      wr_pulse_q <= '0;
      rd_pulse_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q    <= state_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      rd_pulse_q <= rd_pulse_d;
      regs_q     <= regs_d;
    end
  end

  assign wready   = wready_q;
  assign bvalid   = bvalid_q;
  assign arready  = arready_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign wr_pulse = wr_pulse_q;
  assign rd_pulse = rd_pulse_q;

  // Read-only slices come straight from the peripheral.
  for (genvar i = 0; i < NREGS; i++) begin : g_out
    assign regs_out[32*i +: 32] = RO_MASK[i] ? regs_in[32*i +: 32] : regs_q[i];
  end

endmodule
